// File: rtl/paddle_move_ctrl.sv
// paddle_move_ctrl
// Per-player paddle movement controller. Produces the slow sample pulse for
// the button debouncers, decodes their debounced up/down levels and moves
// the paddle: one step on press, auto-repeat after a hold delay, saturating
// at the playfield limits.
//
// Ports
//   clk      system clock
//   rst      asynchronous, active-high reset
//   en       game running; low freezes movement and returns the FSM to IDLE
//   up_db    debounced up level
//   dn_db    debounced down level
//   pulse    one-cycle sample tick (registered, coincident with the internal tick)
//   pos      paddle top y coordinate
//   move_up  one-cycle strobe: pos decreased
//   move_dn  one-cycle strobe: pos increased
//   at_top   pos == POS_MIN
//   at_bot   pos == POS_MAX
//
// Strobe semantics: move_up/move_dn are single-cycle events with no
// back-pressure. They are high only in the cycle after a tick in which pos
// really changed, and always coincide with the new pos value.
module paddle_move_ctrl #(
  parameter int TICK_DIV     = 250000,
  parameter int REPEAT_DELAY = 40,
  parameter int REPEAT_RATE  = 8,
  parameter int POS_W        = 10,
  parameter int POS_MIN      = 0,
  parameter int POS_MAX      = 400,
  parameter int POS_INIT     = 200,
  parameter int STEP         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_db,
  input  logic             dn_db,
  output logic             pulse,
  output logic [POS_W-1:0] pos,
  output logic             move_up,
  output logic             move_dn,
  output logic             at_top,
  output logic             at_bot
);

  localparam int CNT_W  = $clog2(TICK_DIV);
  localparam int POS_XW = POS_W + 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  TICK_PRE  = CNT_W'(TICK_DIV - 2);
  localparam logic [7:0]        DELAY_LIM = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]        RATE_LIM  = 8'(REPEAT_RATE - 1);
  localparam logic [POS_XW-1:0] MIN_X     = POS_XW'(POS_MIN);
  localparam logic [POS_XW-1:0] MAX_X     = POS_XW'(POS_MAX);
  localparam logic [POS_XW-1:0] STEP_X    = POS_XW'(STEP);
  localparam logic [POS_XW-1:0] UP_EDGE   = POS_XW'(POS_MIN + STEP);
  localparam logic [POS_XW-1:0] DN_EDGE   = POS_XW'(POS_MAX - STEP);
  localparam logic [POS_W-1:0]  INIT_POS  = POS_W'(POS_INIT);
  localparam logic              INIT_TOP  = (POS_INIT == POS_MIN);
  localparam logic              INIT_BOT  = (POS_INIT == POS_MAX);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

  // ---------------------------------------------------------------- tick
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == TICK_LAST);

  // pulse is registered one count early so that it is high exactly in the
  // cycle where the counter sits at TICK_DIV-1, i.e. aligned with tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      pulse    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      pulse    <= (tick_cnt == TICK_PRE);
    end
  end

  // ---------------------------------------------------------------- decode
  dir_t dir;

  always_comb begin
    dir = DIR_NONE;
    if (up_db && !dn_db)      dir = DIR_UP;
    else if (dn_db && !up_db) dir = DIR_DN;
  end

  // ---------------------------------------------------------------- FSM
  state_t     state, state_n;
  dir_t       hdir, hdir_n;
  logic [7:0] rcnt, rcnt_n;
  logic [7:0] lim;
  logic       do_step;

  assign lim = (state == REPEAT) ? RATE_LIM : DELAY_LIM;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hdir  <= DIR_NONE;
      rcnt  <= '0;
    end else begin
      state <= state_n;
      hdir  <= hdir_n;
      rcnt  <= rcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    hdir_n  = hdir;
    rcnt_n  = rcnt;
    do_step = 1'b0;
    if (tick) begin
      if (!en) begin
        state_n = IDLE;
        rcnt_n  = '0;
      end else begin
        case (state)
          IDLE: begin
            if (dir != DIR_NONE) begin
              do_step = 1'b1;
              hdir_n  = dir;
              rcnt_n  = '0;
              state_n = DELAY;
            end
          end
          DELAY, REPEAT: begin
            if (dir == DIR_NONE) begin
              state_n = IDLE;
              rcnt_n  = '0;
            end else if (dir != hdir) begin
              // Reversal steps at once and restarts the hold delay.
              do_step = 1'b1;
              hdir_n  = dir;
              rcnt_n  = '0;
              state_n = DELAY;
            end else if (rcnt == lim) begin
              do_step = 1'b1;
              rcnt_n  = '0;
              state_n = REPEAT;
            end else begin
              rcnt_n = rcnt + 8'd1;
            end
          end
          default: begin
            state_n = IDLE;
            rcnt_n  = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- position
  // Both candidates are formed one bit wider than pos so neither the
  // subtraction nor the addition can wrap before saturation is applied.
  logic [POS_XW-1:0] pos_x, up_cand, dn_cand;
  logic [POS_W-1:0]  pos_n;
  logic              mu_n, md_n;

  assign pos_x   = {1'b0, pos};
  assign up_cand = (pos_x < UP_EDGE) ? MIN_X : pos_x - STEP_X;
  assign dn_cand = (pos_x > DN_EDGE) ? MAX_X : pos_x + STEP_X;

  always_comb begin
    pos_n = pos;
    mu_n  = 1'b0;
    md_n  = 1'b0;
    if (do_step) begin
      if (dir == DIR_UP) begin
        pos_n = up_cand[POS_W-1:0];
        mu_n  = (up_cand != pos_x);
      end else if (dir == DIR_DN) begin
        pos_n = dn_cand[POS_W-1:0];
        md_n  = (dn_cand != pos_x);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= INIT_POS;
      move_up <= 1'b0;
      move_dn <= 1'b0;
      at_top  <= INIT_TOP;
      at_bot  <= INIT_BOT;
    end else begin
      pos     <= pos_n;
      move_up <= mu_n;
      move_dn <= md_n;
      at_top  <= (POS_XW'(pos_n) == MIN_X);
      at_bot  <= (POS_XW'(pos_n) == MAX_X);
    end
  end

endmodule

// File: doc/paddle_move_ctrl.md
# paddle_move_ctrl

Per-player paddle movement controller for the pong datapath. Generates the slow sample pulse that clocks the button debouncers, consumes their debounced up/down levels, and sequences paddle position updates: one step on press, then auto-repeat after a hold delay, saturating at the playfield limits. One instance per player; `pos` feeds the paddle renderer and collision logic.

## Interface
- TICK_DIV, 250000: clk cycles per sample tick (≥2).
- REPEAT_DELAY, 40: ticks from first step to first auto-repeat step (1..255).
- REPEAT_RATE, 8: ticks between auto-repeat steps (1..255).
- POS_W, 10: width of position.
- POS_MIN, 0: top limit. POS_MAX, 400: bottom limit. POS_INIT, 200: reset position (POS_MIN ≤ POS_INIT ≤ POS_MAX).
- STEP, 4: pixels per step (≥1, < POS_MAX−POS_MIN).

- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  game running; low freezes movement.
- up_db  in  1  debounced up level.
- dn_db  in  1  debounced down level.
- pulse  out  1  one-cycle sample tick to debouncers.
- pos  out  POS_W  paddle top y coordinate.
- move_up  out  1  one-cycle strobe, pos decreased.
- move_dn  out  1  one-cycle strobe, pos increased.
- at_top  out  1  pos == POS_MIN.
- at_bot  out  1  pos == POS_MAX.

## Operation
- Reset values: pulse 0, pos POS_INIT, move_up 0, move_dn 0, at_top/at_bot per POS_INIT, FSM IDLE, tick counter 0, repeat counter 0. Reset is effective immediately, mid-operation included.
- Tick generator: counter 0..TICK_DIV−1, +1 every clk, wraps to 0; internal tick high when counter == TICK_DIV−1. The tick is free-running, independent of en.
- Direction decode: up_db & ~dn_db → UP; dn_db & ~up_db → DN; otherwise NONE (both pressed = NONE).
- The FSM and the step logic act only in tick cycles; all other cycles hold state.
- States: IDLE, DELAY, REPEAT; held direction register hdir.
- IDLE: dir ≠ NONE → step(dir), hdir=dir, rcnt=0, go to DELAY.
- DELAY: dir NONE → IDLE. dir ≠ hdir → step(dir), hdir=dir, rcnt=0, stay. Otherwise, if rcnt (pre-increment) == REPEAT_DELAY−1 → step, rcnt=0, go to REPEAT; else rcnt+1.
- REPEAT: same as DELAY, using REPEAT_RATE−1 as the compare value, and staying in REPEAT on a repeat step. A reversal from REPEAT steps immediately and goes to DELAY.
- en low in a tick cycle: FSM → IDLE, rcnt=0, no step; pos held.
- step(UP): pos = (pos < POS_MIN+STEP) ? POS_MIN : pos−STEP.
- step(DN): pos = (pos > POS_MAX−STEP) ? POS_MAX : pos+STEP.
- Compute both in POS_W+1 bits; no wrap-around is permitted.
- move_up/move_dn assert only if pos actually changes. A saturated step is a silent no-op, but still counts for repeat timing.
- at_top/at_bot are registered from the next pos value.

## Timing
- pulse is registered: high for exactly one cycle every TICK_DIV cycles, first in the cycle where the counter == TICK_DIV−1 (the TICK_DIV-th cycle after reset release).
- Debouncer outputs change the cycle after pulse. The controller samples them at the following tick, so press-to-step latency is one tick.
- pos, move strobes, at_top and at_bot update on the clk edge ending the tick cycle. A strobe is high for the single cycle after the tick, coincident with the new pos.
- Held input: steps at tick T0, T0+REPEAT_DELAY, then every REPEAT_RATE ticks.
- At most one step per tick.

## Test plan
Bench parameters: TICK_DIV=4, REPEAT_DELAY=3, REPEAT_RATE=2, STEP=4, POS_MIN=0, POS_MAX=20, POS_INIT=8.
- Reset, then idle for 12 cycles: pos=8, strobes 0, at_top=0, at_bot=0. pulse is high only in cycles 4, 8 and 12 after release.
- dn_db high across exactly one tick: pos=12 and one move_dn pulse after that tick; the FSM returns to IDLE on the next tick with dn_db low.
- up_db held from tick T0:
  - pos 8→4 at T0, →0 at T0+3, with at_top=1.
  - Ticks T0+5 and T0+7 leave pos at 0 with no move_up.
- up_db and dn_db both high for 5 ticks: pos unchanged and no strobes. Drop up_db: pos 8→12 on the next tick.
- Hold dn into REPEAT (pos 8→12 at T0, →16 at T0+3), then switch to up at T0+4: pos=12 at T0+4, and the next up step (→8) occurs at T0+7.
- Hold up, then drop en mid-DELAY: no step while en=0; re-raising en steps on the first tick.
- Assert rst asynchronously mid-REPEAT: pos=8 and pulse=0 immediately, with no strobe.
